tt_bist_harness: RTL
====================

# tt_bist_harness

Parametrised on-chip built-in self-test harness for Tiny Tapeout user designs. It generates a pseudo-random stimulus stream on a configurable-width channel and applies it to a wrapped design. It compresses that design's responses into a multiple-input signature register (MISR) and reports a final signature through a start/done handshake. It sits between the top-level pins and the user core, so the stimulus and capture that the simulation bench performs can run on silicon.

## Interface

Parameters:
- WIDTH, 8: stimulus/response channel width (2..16).
- LFSR_TAPS, 8'hB8: feedback tap mask for the stimulus LFSR, WIDTH bits.
- MISR_TAPS, 8'hB8: feedback tap mask for the MISR, WIDTH bits.
- SEED, 8'h01: LFSR load value at start. Must be nonzero.
- CNT_W, 16: width of the pattern-count input.
- DUT_LAT, 1: cycles from driving dut_in to sampling dut_out (0..15).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- ena  in  1  enable; when low, all internal state holds
- start  in  1  begin a run; sampled only in IDLE with ena=1
- count  in  CNT_W  number of patterns; latched on accepted start
- dut_in  out  WIDTH  stimulus to wrapped design
- dut_out  in  WIDTH  response from wrapped design
- busy  out  1  run in progress
- done  out  1  run complete; signature valid
- signature  out  WIDTH  MISR contents

## Operation

- States:
  - IDLE: waiting for start.
  - DRIVE: pattern applied; wait counter running.
  - CAPTURE: dut_out folded into MISR.
  - DONE: result valid.
- IDLE -> DRIVE on start & ena & count!=0:
  - LFSR <= SEED, MISR <= 0, remaining <= count, wait <= 0, done <= 0.
- IDLE -> DONE on start & ena & count==0:
  - MISR <= 0; no pattern driven.
- DRIVE:
  - dut_in = LFSR.
  - wait increments each cycle.
  - Go to CAPTURE when wait==DUT_LAT.
  - DUT_LAT=0: CAPTURE is entered in the same cycle as DRIVE, i.e. DRIVE and CAPTURE merge into one cycle per pattern.
- CAPTURE:
  - MISR <= {MISR[W-2:0], ^(MISR & MISR_TAPS)} ^ dut_out.
  - LFSR <= {LFSR[W-2:0], ^(LFSR & LFSR_TAPS)}.
  - remaining decrements.
  - Goes to DRIVE (wait<=0) if remaining>1, else to DONE.
- DONE:
  - done=1; signature holds the final MISR.
  - start & ena relaunches directly, with the same rules as from IDLE.
- start is ignored while busy. count is sampled only at accepted start.
- ena low: state, counters, LFSR and MISR freeze; outputs hold their current values.
- Reset values:
  - state IDLE
  - dut_in 0 (driven 0 in IDLE and DONE)
  - busy 0
  - done 0
  - signature 0
  - LFSR = SEED, MISR = 0
- Reset asserted mid-run aborts immediately and asynchronously to reset values. No partial signature is retained.

## Timing

- busy = 1 exactly in DRIVE/CAPTURE; registered; rises the cycle after the accepted start.
- Per-pattern period is DUT_LAT+1 cycles. A run of N patterns completes with done rising N*(DUT_LAT+1)+1 cycles after the start edge.
- count==0: done rises 1 cycle after start and busy never rises.
- done is a level, held until the next accepted start or reset. It drops the cycle after that start.
- signature is combinationally the MISR register. It is only meaningful while done=1.
- dut_out is sampled on the clk edge ending the CAPTURE cycle. The wrapped design must be valid DUT_LAT cycles after dut_in changes.
- Remaining counter width is CNT_W. The full count range up to 2^CNT_W-1 must work without wrap.

## Test plan

- Loopback, dut_out=dut_in, defaults with DUT_LAT=0, count=5 -> dut_in sequence 01,02,04,08,11; busy high 5 cycles; done then high.
- Loopback, DUT_LAT=0, count=3 -> signature 8'h04 (MISR 01, 00, 04).
- dut_out tied 0, count=200, DUT_LAT=1 -> signature 8'h00; done rises 401 cycles after start.
- count=0 -> busy stays 0, done=1 one cycle after start, signature 8'h00.
- Run with ena low for 10 cycles mid-run -> dut_in frozen; final signature and done timing shifted by exactly 10 cycles versus the uninterrupted run.
- rst_n low mid-run, then a new start with count=3 in loopback -> immediate reset values; re-run yields signature 8'h04. start pulses during busy are ignored.

Source files
------------

// File: rtl/tt_bist_harness.sv
// tt_bist_harness: LFSR stimulus generator plus MISR response compactor
// wrapped around a user design, with a start/done handshake.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// S_IDLE    | waiting for start; dut_in driven 0
// S_DRIVE   | pattern applied; wait counter runs until DUT_LAT elapses
// S_CAPTURE | dut_out folded into MISR; LFSR advances to next pattern
// S_DONE    | run complete; signature valid until next accepted start
module tt_bist_harness #(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] LFSR_TAPS = 8'hB8,
  parameter logic [WIDTH-1:0] MISR_TAPS = 8'hB8,
  parameter logic [WIDTH-1:0] SEED      = 8'h01,
  parameter int               CNT_W     = 16,
  parameter int               DUT_LAT   = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             start,
  input  logic [CNT_W-1:0] count,
  output logic [WIDTH-1:0] dut_in,
  input  logic [WIDTH-1:0] dut_out,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] signature
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_DRIVE   = 2'd1,
    S_CAPTURE = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  // With zero latency the drive and capture phases collapse into one cycle,
  // so each pattern starts directly in CAPTURE.
  localparam state_t     FIRST_ST = (DUT_LAT == 0) ? S_CAPTURE : S_DRIVE;
  localparam logic [4:0] LAT5     = 5'(DUT_LAT);

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   lfsr_q, lfsr_d;
  logic [WIDTH-1:0]   misr_q, misr_d;
  logic [CNT_W-1:0]   remaining_q, remaining_d;
  logic [3:0]         wait_q, wait_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  // Next-state and datapath update; everything is held by the register
  // process when ena is low.
  always_comb begin
    state_d     = state_q;
    lfsr_d      = lfsr_q;
    misr_d      = misr_q;
    remaining_d = remaining_q;
    wait_d      = wait_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          lfsr_d      = SEED;
          misr_d      = '0;
          remaining_d = count;
          wait_d      = '0;
          state_d     = (count != '0) ? FIRST_ST : S_DONE;
        end
      end
      S_DRIVE: begin
        wait_d = wait_q + 4'd1;
        if (({1'b0, wait_q} + 5'd1) == LAT5) state_d = S_CAPTURE;
      end
      S_CAPTURE: begin
        misr_d      = {misr_q[WIDTH-2:0], ^(misr_q & MISR_TAPS)} ^ dut_out;
        lfsr_d      = {lfsr_q[WIDTH-2:0], ^(lfsr_q & LFSR_TAPS)};
        remaining_d = remaining_q - 1'b1;
        wait_d      = '0;
        state_d     = (remaining_q > 1) ? FIRST_ST : S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d == S_DRIVE) || (state_d == S_CAPTURE);
    done_d = (state_d == S_DONE);
  end

  // State and datapath registers; ena freezes the whole harness.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      lfsr_q      <= SEED;
      misr_q      <= '0;
      remaining_q <= '0;
      wait_q      <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else if (ena) begin
      state_q     <= state_d;
      lfsr_q      <= lfsr_d;
      misr_q      <= misr_d;
      remaining_q <= remaining_d;
      wait_q      <= wait_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  // busy_q tracks DRIVE/CAPTURE exactly, so it gates the stimulus to 0
  // outside a run.
  assign dut_in    = busy_q ? lfsr_q : '0;
  assign busy      = busy_q;
  assign done      = done_q;
  assign signature = misr_q;

endmodule
